// File: rtl/text_overlay.sv
// rtl/text_overlay.sv - string overlay using an external 8x16 font ROM, 2-cycle pixel pipeline
module text_overlay #(
    parameter int          NCHARS       = 8,
    parameter int          CODE_W       = 7,
    parameter int          GAP          = 4,
    parameter logic [9:0]  X0           = 10'd303,
    parameter logic [9:0]  Y0           = 10'd232,
    parameter logic [2:0]  COLOR0       = 3'b111,
    parameter int          BLINK_FRAMES = 30,
    localparam int         AW           = (NCHARS > 1) ? $clog2(NCHARS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              frame_tick,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CODE_W:0]   wr_data,
    input  logic              cfg_load,
    input  logic [9:0]        cfg_x,
    input  logic [9:0]        cfg_y,
    input  logic [2:0]        cfg_rgb,
    output logic [CODE_W+3:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [2:0]        rgb_text,
    output logic              video_on_d
);
    localparam int          P      = 8 + GAP;
    localparam logic [10:0] BOX_W  = 11'(NCHARS * P);
    localparam logic [3:0]  P_LAST = 4'(P - 1);
    localparam logic [AW:0] NCH    = (AW + 1)'(NCHARS);
    localparam int          FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    logic [CODE_W:0] ram [NCHARS];
    logic [9:0]      org_x, org_y, sh_x, sh_y;
    logic [2:0]      color_active, sh_rgb;
    logic [FW-1:0]   frame_cnt;
    logic            blink_phase;

    logic [AW-1:0]   slot_q, cur_slot;
    logic [3:0]      col_q, cur_col;
    logic [9:0]      dy;
    logic [10:0]     x_end;
    logic            in_x, in_y, slot_ok, hidden, vis0;
    logic [CODE_W:0] entry;

    logic            vis1, von1;
    logic [2:0]      col1;

    // Slot/column follow pixel_x: restart at the box origin, otherwise advance one pixel per cycle
    always_comb begin
        cur_slot = slot_q;
        cur_col  = col_q + 4'd1;
        if (pixel_x == org_x) begin
            cur_slot = '0;
            cur_col  = '0;
        end else if (col_q == P_LAST) begin
            cur_slot = slot_q + AW'(1);
            cur_col  = '0;
        end
    end

    always_comb begin
        dy       = pixel_y - org_y;
        x_end    = {1'b0, org_x} + BOX_W;
        in_x     = (pixel_x >= org_x) && ({1'b0, pixel_x} < x_end);
        in_y     = (pixel_y >= org_y) && (dy[9:4] == 6'd0);
        slot_ok  = ({1'b0, cur_slot} < NCH);
        entry    = slot_ok ? ram[cur_slot] : '0;
        hidden   = entry[CODE_W] & blink_phase;
        rom_addr = {entry[CODE_W-1:0], dy[3:0]};
        vis0     = video_on & in_x & in_y & slot_ok & (cur_col < 4'd8) & ~hidden;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= '0;
            col_q      <= '0;
            vis1       <= 1'b0;
            von1       <= 1'b0;
            col1       <= '0;
            rgb_text   <= 3'b000;
            video_on_d <= 1'b0;
        end else begin
            slot_q     <= cur_slot;
            col_q      <= cur_col;
            vis1       <= vis0;
            von1       <= video_on;
            col1       <= cur_col[2:0];
            rgb_text   <= (vis1 && rom_data[3'd7 - col1]) ? color_active : 3'b000;
            video_on_d <= von1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCHARS; i++) ram[i] <= '0;
        end else if (wr_en && ({1'b0, wr_addr} < NCH)) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // Origin/color only change at frame start; a load coinciding with the tick wins over the shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x         <= X0;
            sh_y         <= Y0;
            sh_rgb       <= COLOR0;
            org_x        <= X0;
            org_y        <= Y0;
            color_active <= COLOR0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
        end else begin
            if (cfg_load) begin
                sh_x   <= cfg_x;
                sh_y   <= cfg_y;
                sh_rgb <= cfg_rgb;
            end
            if (frame_tick) begin
                org_x        <= cfg_load ? cfg_x   : sh_x;
                org_y        <= cfg_load ? cfg_y   : sh_y;
                color_active <= cfg_load ? cfg_rgb : sh_rgb;
                if (frame_cnt == F_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_text_overlay.sv
// tb/tb_text_overlay.sv - directed self-checking bench for text_overlay
module tb_text_overlay;
    localparam int NCH = 6;
    localparam int P   = 12;
    localparam int BF  = 2;

    logic        clk = 1'b0;
    logic        rst, video_on, frame_tick, wr_en, cfg_load;
    logic [9:0]  pixel_x, pixel_y, cfg_x, cfg_y;
    logic [2:0]  wr_addr, cfg_rgb, rgb_text;
    logic [7:0]  wr_data, rom_data;
    logic [10:0] rom_addr;
    logic        video_on_d;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_ram [NCH];
    int         m_ox, m_oy, m_shx, m_shy, m_cnt;
    logic [2:0] m_col, m_shc;
    logic       m_phase;

    text_overlay #(.NCHARS(NCH), .CODE_W(7), .GAP(4), .X0(10'd303), .Y0(10'd232),
                   .COLOR0(3'b111), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_tick(frame_tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_load(cfg_load), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_rgb(cfg_rgb),
        .rom_addr(rom_addr), .rom_data(rom_data), .rgb_text(rgb_text), .video_on_d(video_on_d)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] font(input logic [6:0] code, input logic [3:0] row);
        logic [7:0] v;
        if (code == 7'd0) return 8'h00;
        v = 8'(code * 8'd29);
        return v ^ {row, ~row};
    endfunction

    always @(posedge clk) rom_data <= font(rom_addr[10:4], rom_addr[3:0]);

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) m_ram[i] = 8'h00;
        m_ox = 303; m_oy = 232; m_shx = 303; m_shy = 232;
        m_col = 3'b111; m_shc = 3'b111; m_cnt = 0; m_phase = 1'b0;
    endtask

    task automatic m_tick();
        m_ox = m_shx; m_oy = m_shy; m_col = m_shc;
        if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = ~m_phase; end
        else m_cnt++;
    endtask

    function automatic logic in_box(input int x, input int y);
        return (x >= m_ox) && (x < m_ox + NCH * P) && (y >= m_oy) && (y < m_oy + 16);
    endfunction

    function automatic logic [2:0] exp_pix(input int x, input int y);
        int k, c;
        logic [7:0] f;
        if (!in_box(x, y)) return 3'b000;
        k = (x - m_ox) / P;
        c = (x - m_ox) % P;
        if (c >= 8) return 3'b000;
        if (m_ram[k][7] && m_phase) return 3'b000;
        f = font(m_ram[k][6:0], 4'(y - m_oy));
        return f[7 - c] ? m_col : 3'b000;
    endfunction

    task automatic sweep(input int xs, input int xe, input int y);
        logic [2:0] ex [0:1023];
        int k;
        for (int x = xs; x <= xe + 2; x++) begin
            @(negedge clk);
            if (x - 2 >= xs) begin
                chk($sformatf("rgb x=%0d y=%0d", x - 2, y), 32'(rgb_text), 32'(ex[x - 2]));
                chk("video_on_d", 32'(video_on_d), 32'd1);
            end
            if (x <= xe) begin
                video_on = 1'b1; pixel_x = 10'(x); pixel_y = 10'(y);
                ex[x] = exp_pix(x, y);
                #1;
                if (in_box(x, y)) begin
                    k = (x - m_ox) / P;
                    chk($sformatf("rom_addr x=%0d", x), 32'(rom_addr),
                        32'({m_ram[k][6:0], 4'(y - m_oy)}));
                end
            end else begin
                video_on = 1'b0;
            end
        end
        @(negedge clk);
        chk("video_on_d off", 32'(video_on_d), 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < NCH) m_ram[a] = d;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        m_tick();
    endtask

    task automatic cfg(input int x, input int y, input logic [2:0] c);
        @(negedge clk);
        cfg_load = 1'b1; cfg_x = 10'(x); cfg_y = 10'(y); cfg_rgb = c;
        @(negedge clk);
        cfg_load = 1'b0;
        m_shx = x; m_shy = y; m_shc = c;
    endtask

    task automatic write_defaults();
        wr(3'd0, 8'h49);
        wr(3'd1, 8'h45);
        wr(3'd2, 8'h41);
        wr(3'd3, 8'h33);
        wr(3'd4, 8'h7E);
        wr(3'd5, 8'h2B);
    endtask

    initial begin
        rst = 1'b1; video_on = 1'b0; pixel_x = '0; pixel_y = '0; frame_tick = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; cfg_load = 1'b0; cfg_x = '0; cfg_y = '0;
        cfg_rgb = '0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("reset rgb_text", 32'(rgb_text), 32'd0);
        chk("reset video_on_d", 32'(video_on_d), 32'd0);
        rst = 1'b0;

        // Blank RAM after reset: box addresses code 0, nothing lit
        sweep(298, 380, 232);

        // 'I' in slot 0, other slots filled; first glyph pixel lands at 303
        write_defaults();
        sweep(298, 380, 232);
        sweep(298, 380, 247);
        sweep(298, 380, 248);
        sweep(298, 380, 231);

        // Hand-computed: 'I' row 0 = 0x4A -> x=304 lit (bit6), x=303 dark (bit7)
        chk("hand I row0", 32'(exp_pix(304, 232)), 32'd7);

        // Mid-frame load is deferred until frame_tick
        cfg(100, 240, 3'b010);
        sweep(95, 380, 240);
        tick();
        sweep(95, 380, 240);
        sweep(95, 180, 255);

        // Coincident load and tick applies the new values immediately
        @(negedge clk);
        cfg_load = 1'b1; frame_tick = 1'b1; cfg_x = 10'd303; cfg_y = 10'd232; cfg_rgb = 3'b101;
        m_shx = 303; m_shy = 232; m_shc = 3'b101;
        m_tick();
        @(negedge clk);
        cfg_load = 1'b0; frame_tick = 1'b0;
        sweep(298, 380, 232);

        // Out-of-range write addresses leave every slot untouched
        wr(3'd6, 8'h11);
        wr(3'd7, 8'h22);
        sweep(298, 380, 232);

        // Reset mid-line, with a write and cfg_load in the same cycle
        for (int x = 300; x < 310; x++) begin
            @(negedge clk);
            video_on = 1'b1; pixel_x = 10'(x); pixel_y = 10'd232;
        end
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h33;
        cfg_load = 1'b1; cfg_x = 10'd50; cfg_y = 10'd50; cfg_rgb = 3'b001;
        pixel_x = 10'd310;
        @(negedge clk);
        chk("rst mid-line rgb", 32'(rgb_text), 32'd0);
        chk("rst mid-line von_d", 32'(video_on_d), 32'd0);
        rst = 1'b0; wr_en = 1'b0; cfg_load = 1'b0; video_on = 1'b0;
        m_reset();
        sweep(298, 380, 232);
        tick();
        sweep(298, 380, 232);

        // Blink: fresh reset so the frame numbering starts at 0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_reset();
        write_defaults();
        wr(3'd2, 8'hC1);
        for (int f = 0; f < 5; f++) begin
            sweep(298, 380, 232);
            chk($sformatf("blink slot2 frame %0d", f), 32'(exp_pix(328, 232) != 3'b000),
                32'((f == 2 || f == 3) ? 0 : 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/text_overlay.md
TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 SHALL have parameter NCHARS, default 8: number of character slots in the string.
REQ-002 SHALL have parameter CODE_W, default 7: glyph code width (up to 128 glyphs).
REQ-003 SHALL have parameter GAP, default 4, legal range 0..8: blank pixels between glyphs; pitch P = 8+GAP.
REQ-004 SHALL have parameters X0 (default 303), Y0 (default 232), COLOR0 (default 3'b111) and BLINK_FRAMES (default 30): reset origin, reset color and blink half-period in frames.
REQ-005 clk  in  1  pixel clock.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 video_on, pixel_x[9:0], pixel_y[9:0]  in  visible flag and pixel coordinates.
REQ-008 frame_tick  in  1  one-cycle pulse at frame start.
REQ-009 wr_en, wr_addr[clog2(NCHARS)-1:0], wr_data[CODE_W:0]  in  character RAM write; wr_data[CODE_W] is the blink flag, the remaining bits are the code.
REQ-010 cfg_load, cfg_x[9:0], cfg_y[9:0], cfg_rgb[2:0]  in  origin and color update request.
REQ-011 rom_addr[CODE_W+3:0]  out  {code,row} to the external 8x16 font ROM; rom_data[7:0]  in  ROM data, 1-cycle latency.
REQ-012 rgb_text[2:0], video_on_d  out  pixel color and video_on delayed to match it.

Function
REQ-013 Text box: x in [org_x, org_x+NCHARS*P-1], y in [org_y, org_y+15]; slot k = (x-org_x)/P; column c = (x-org_x) mod P; row = y-org_y.
REQ-014 Columns c >= 8 (the gap) and all pixels outside the box SHALL render black.
REQ-015 The datapath SHALL NOT use a general divider; slot and column SHALL be derived from a slot counter and a column counter that track pixel_x along the line.
REQ-016 Pipeline: cycle 0 registers slot lookup and row and drives rom_addr; cycle 1 rom_data returns; cycle 2 rgb_text is registered. Total latency from pixel inputs to rgb_text and video_on_d SHALL be exactly 2 cycles.
REQ-017 Pixel SHALL be lit when rom_data[7-c]=1, inside the box, video_on delayed = 1, and the pixel is not blink-hidden; a lit pixel outputs color_active, otherwise 3'b000.
REQ-018 Character RAM: NCHARS entries of CODE_W+1 bits; a write takes effect on the clock edge; the written data is visible to lookups on the following cycle.
REQ-019 wr_addr >= NCHARS SHALL be ignored without changing any slot.
REQ-020 cfg_load SHALL capture cfg_x, cfg_y and cfg_rgb into shadow registers; the shadow SHALL be copied to org_x, org_y and color_active only on frame_tick, so no mid-frame tearing occurs.
REQ-021 When cfg_load and frame_tick coincide, the incoming cfg values SHALL be applied at that frame_tick.
REQ-022 Blink: a frame counter counts frame_tick pulses 0..BLINK_FRAMES-1 and wraps to 0, toggling blink_phase on each wrap; slots with blink flag = 1 SHALL be hidden while blink_phase = 1.
REQ-023 Box pixels beyond x = 639 or y = 479 SHALL be clipped naturally, because those coordinates are never presented.

Reset
REQ-024 On rst: rgb_text=0, video_on_d=0, all RAM entries=0 (code 0 = blank glyph, no blink), org_x=X0, org_y=Y0, color_active and shadow color=COLOR0, blink counter=0, blink_phase=0, pipeline registers cleared.
REQ-025 rst asserted mid-frame SHALL blank output from the next edge; the first valid pixel SHALL appear 2 cycles after rst is released.
REQ-026 Writes and cfg_load in the same cycle as rst SHALL be discarded.

Verification
REQ-027 Write code 'I' to slot 0 and defaults elsewhere; sweep row y=232 -> lit pixels at x=303..310 follow the ROM row pattern, 2-cycle latency, x=311..314 black.
REQ-028 NCHARS=8, GAP=4: pixel x=303+7*12+3=390 -> ROM address uses slot 7 code; x=399 (beyond 398) -> black.
REQ-029 cfg_load x=100 mid-frame -> origin unchanged until next frame_tick, then the box starts at x=100; a coincident load and tick -> applied immediately.
REQ-030 Set slot 2 blink flag, BLINK_FRAMES=2 -> slot 2 is visible for frames 0-1, hidden for frames 2-3, visible again; other slots are always visible.
REQ-031 wr_addr=9 with NCHARS=8 -> no RAM change; rst pulsed mid-line -> rgb_text=0 next cycle, and all slots read as blank afterwards.
